// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM states, line mode constants and baud divisor helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam logic STOP_1   = 1'b0;
    localparam logic STOP_2   = 1'b1;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int BAUD_DIV_MIN = 4;

    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Below four clocks per bit the tx_done look-ahead (count == DIV-2) has no room.
    function automatic bit baud_div_ok(input int clk_freq, input int baud_rate);
        return calc_baud_div(clk_freq, baud_rate) >= BAUD_DIV_MIN;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit-period counter with clear and end-of-bit tick
module uart_baud_gen #(
    parameter int BAUD_DIV = 4,
    parameter int CNT_W    = $clog2(BAUD_DIV)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick  = (r_count == LAST);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - FIFO-fed UART transmitter, LSB first; parity built only with UART_TX_PARITY_EN
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 200_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int D_WIDTH   = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cfg_tx_en,
    input  logic               cfg_stop2,
    input  logic               cfg_par_en,
    input  logic               cfg_par_odd,
    input  logic               rfifo_empty,
    input  logic [D_WIDTH-1:0] rfifo_rd_data,
    output logic               rfifo_rd_en,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(D_WIDTH + 1);

    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(D_WIDTH - 1);
    localparam logic [CNT_W-1:0] DONE_CNT      = CNT_W'(BAUD_DIV - 2);

    generate
        if (!baud_div_ok(CLK_FREQ, BAUD_RATE)) begin : g_bad_baud
            $error("uart_tx_frame: BAUD_DIV must be at least 4");
        end
        if ((D_WIDTH < 5) || (D_WIDTH > 9)) begin : g_bad_width
            $error("uart_tx_frame: D_WIDTH must be 5..9");
        end
    endgenerate

    uart_state_t        r_state;
    logic [D_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_stop2;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;
    logic               w_tick;
    logic [CNT_W-1:0]   w_baud_cnt;
    logic               w_baud_clr;
    logic               w_last_stop;

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_odd;
    logic r_par_acc;
`else
    logic w_unused_par;
    assign w_unused_par = cfg_par_en ^ cfg_par_odd;
`endif

    assign rfifo_rd_en = (r_state == ST_IDLE) && cfg_tx_en && !rfifo_empty && !sys_rst;
    // Holding the counter clear outside bit states makes START begin at count 0.
    assign w_baud_clr  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_last_stop = (r_stop2 == STOP_2) ? (r_bit_cnt == BIT_W'(1)) : (r_bit_cnt == '0);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baud (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_clear (w_baud_clr),
        .o_tick  (w_tick),
        .o_count (w_baud_cnt)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_stop2   <= STOP_1;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_odd <= PAR_EVEN;
            r_par_acc <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rfifo_rd_en) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_shift   <= rfifo_rd_data;
                    r_stop2   <= cfg_stop2;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                    r_par_en  <= cfg_par_en;
                    r_par_odd <= cfg_par_odd;
                    r_par_acc <= 1'b0;
`endif
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
`ifdef UART_TX_PARITY_EN
                        r_par_acc <= r_par_acc ^ r_shift[0];
`endif
                        if (r_bit_cnt == LAST_DATA_BIT) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_tx    <= r_par_acc ^ r_shift[0] ^ r_par_odd;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Raised one clock early so the pulse lands in the frame's final clock.
                    if (w_last_stop && (w_baud_cnt == DONE_CNT)) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed bench for uart_tx_frame with BAUD_DIV = 4, D_WIDTH = 8
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int DIV = 4;

    logic       sys_clk;
    logic       sys_rst;
    logic       cfg_tx_en;
    logic       cfg_stop2;
    logic       cfg_par_en;
    logic       cfg_par_odd;
    logic       rfifo_empty;
    logic [7:0] rfifo_rd_data;
    logic       rfifo_rd_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    uart_tx_frame #(
        .CLK_FREQ  (40),
        .BAUD_RATE (10),
        .D_WIDTH   (8)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cfg_tx_en     (cfg_tx_en),
        .cfg_stop2     (cfg_stop2),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_odd   (cfg_par_odd),
        .rfifo_empty   (rfifo_empty),
        .rfifo_rd_data (rfifo_rd_data),
        .rfifo_rd_en   (rfifo_rd_en),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    assign rfifo_empty = (rd_ptr == wr_ptr);

    always @(posedge sys_clk) begin
        if (rfifo_rd_en) begin
            rfifo_rd_data <= mem[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
            rd_cnt        <= rd_cnt + 1;
        end
    end

    always @(negedge sys_clk) begin
        if (tx_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit par, input bit odd, input bit stop2,
                             input int drop_at, input string nm, output int gap);
        logic exp_bits [0:11];
        int nb, len, bad_tx, bad_done, bad_busy;
        nb = 0;
        exp_bits[nb] = 1'b0; nb = nb + 1;
        for (int i = 0; i < 8; i++) begin
            exp_bits[nb] = d[i]; nb = nb + 1;
        end
        if (par && PAR_BUILD) begin
            exp_bits[nb] = (^d) ^ odd; nb = nb + 1;
        end
        exp_bits[nb] = 1'b1; nb = nb + 1;
        if (stop2) begin
            exp_bits[nb] = 1'b1; nb = nb + 1;
        end
        len = nb * DIV;
        gap = 0;
        while (tx !== 1'b0 && gap < 300) begin
            @(negedge sys_clk);
            gap = gap + 1;
        end
        n_chk++;
        if (gap >= 300) begin
            n_err++;
            $display("FAIL %s start: tx never fell within %0d cycles, required a start bit", nm, gap);
            return;
        end
        bad_tx = 0; bad_done = 0; bad_busy = 0;
        for (int c = 1; c <= len; c++) begin
            if (c > 1) @(negedge sys_clk);
            if (c == drop_at) cfg_tx_en = 1'b0;
            if (tx !== exp_bits[(c - 1) / DIV]) bad_tx++;
            if (tx_done !== (c == len)) bad_done++;
            if (tx_busy !== 1'b1) bad_busy++;
        end
        n_chk++;
        if (bad_tx != 0) begin
            n_err++;
            $display("FAIL %s bits: %0d of %0d cycles had wrong tx, required 0", nm, bad_tx, len);
        end
        n_chk++;
        if (bad_done != 0) begin
            n_err++;
            $display("FAIL %s done: %0d cycles with wrong tx_done, required only cycle %0d high", nm, bad_done, len);
        end
        n_chk++;
        if (bad_busy != 0) begin
            n_err++;
            $display("FAIL %s busy: %0d frame cycles with tx_busy low, required 0", nm, bad_busy);
        end
        @(negedge sys_clk);
        n_chk++;
        if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after: tx=%b done=%b busy=%b, required 1 0 0", nm, tx, tx_done, tx_busy);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; cfg_tx_en = 1'b0; cfg_stop2 = 1'b0; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_chk++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || rfifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b rd_en=%b, required 1 0 0 0",
                     tx, tx_busy, tx_done, rfifo_rd_en);
        end
        push(8'hA5);
        cfg_tx_en = 1'b1;
        @(negedge sys_clk);
        n_chk++;
        if (rfifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd_en: rd_en=%b during reset, required 0", rfifo_rd_en);
        end
    endtask

    task automatic test_basic();
        int r0, g;
        r0 = rd_cnt;
        sys_rst = 1'b0;
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, "basic_a5", g);
        repeat (4) @(negedge sys_clk);
        n_chk++;
        if (rd_cnt - r0 != 1) begin
            n_err++;
            $display("FAIL basic_rd_cnt: %0d reads, required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_parity();
        int g;
        cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
        push(8'hA5);
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, "parity_even", g);
        cfg_par_odd = 1'b1;
        push(8'hA5);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0, "parity_odd", g);
        cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    endtask

    task automatic test_back_to_back();
        int r0, g;
        logic [7:0] bytes [0:2];
        bytes[0] = 8'h3C; bytes[1] = 8'h81; bytes[2] = 8'hFF;
        r0 = rd_cnt;
        cfg_stop2 = 1'b1;
        push(bytes[0]); push(bytes[1]); push(bytes[2]);
        for (int k = 0; k < 3; k++) begin
            run_frame(bytes[k], 1'b0, 1'b0, 1'b1, 0, "stop2_b2b", g);
            if (k > 0) begin
                n_chk++;
                if (g != 2) begin
                    n_err++;
                    $display("FAIL b2b_gap: frame %0d gap %0d cycles, required 2", k, g);
                end
            end
        end
        repeat (4) @(negedge sys_clk);
        cfg_stop2 = 1'b0;
        n_chk++;
        if (rd_cnt - r0 != 3) begin
            n_err++;
            $display("FAIL b2b_rd_cnt: %0d reads, required 3", rd_cnt - r0);
        end
    endtask

    task automatic test_tx_en_drop();
        int r0, g, bad;
        r0 = rd_cnt;
        push(8'h11); push(8'h5A);
        run_frame(8'h11, 1'b0, 1'b0, 1'b0, 12, "en_drop", g);
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (rfifo_rd_en !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL en_drop_idle: %0d cycles with read or tx low, required 0", bad);
        end
        n_chk++;
        if (rd_cnt - r0 != 1) begin
            n_err++;
            $display("FAIL en_drop_rd_cnt: %0d reads, required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0, d0, k, g;
        r0 = rd_cnt; d0 = done_cnt;
        push(8'hC3);
        cfg_tx_en = 1'b1;
        k = 0;
        while (tx !== 1'b0 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        n_chk++;
        if (k >= 50) begin
            n_err++;
            $display("FAIL rst_mid_start: no start bit in %0d cycles, required one", k);
        end
        repeat (10) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_chk++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || rfifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_state: tx=%b busy=%b done=%b rd_en=%b, required 1 0 0 0",
                     tx, tx_busy, tx_done, rfifo_rd_en);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 0, "rst_mid_next", g);
        n_chk++;
        if (rd_cnt - r0 != 2) begin
            n_err++;
            $display("FAIL rst_mid_rd_cnt: %0d reads, required 2", rd_cnt - r0);
        end
        n_chk++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL rst_mid_done_cnt: %0d tx_done pulses, required 1", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_tx_en_drop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that pulls bytes from a read FIFO and serialises them LSB first. Data width, baud divisor and stop-bit count are configurable, and parity is optional. Sits between the rFIFO read port and the board TX pin. It is the general-purpose transmitter for the SDRAM controller debug/readback path.

## Interface
- CLK_FREQ, 200_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line baud rate; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division), must be ≥ 4
- D_WIDTH, 8, data bits per frame, legal range 5..9
- sys_clk  in  1  system clock; all logic on its rising edge
- sys_rst  in  1  reset, synchronous, active-high
- cfg_tx_en  in  1  1 = allow new frames; 0 = finish current frame, then stay idle
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
- cfg_par_en  in  1  1 = insert parity bit (ignored when parity is compiled out)
- cfg_par_odd  in  1  0 = even parity, 1 = odd parity
- rfifo_empty  in  1  FIFO empty flag
- rfifo_rd_data  in  D_WIDTH  FIFO read data, valid the cycle after rfifo_rd_en
- rfifo_rd_en  out  1  one-cycle read strobe
- tx  out  1  serial line, registered, idle high
- tx_busy  out  1  high from LOAD through the end of the last stop bit
- tx_done  out  1  one-cycle pulse in the final clock of the last stop bit

## Operation
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: rfifo_rd_en = cfg_tx_en & ~rfifo_empty, combinational and registered-free; asserting it moves the FSM to LOAD.
- LOAD, one cycle: capture rfifo_rd_data into the shift register; latch cfg_stop2, cfg_par_en and cfg_par_odd for the whole frame; clear the parity accumulator; go to START.
- START: tx = 0 for BAUD_DIV clocks.
- DATA: D_WIDTH bits, LSB first, BAUD_DIV clocks each. Parity accumulator XORs each bit sent.
- PARITY: entered only when parity is latched enabled. Bit = accumulator ^ par_odd.
- STOP: tx = 1 for BAUD_DIV clocks, or 2×BAUD_DIV when stop2 is latched; then return to IDLE.
- Baud counter runs 0..BAUD_DIV-1. It is cleared on every state entry, and the bit tick fires at count BAUD_DIV-1.
- Bit counter width is $clog2(D_WIDTH+1); baud counter width is $clog2(BAUD_DIV).
- rfifo_rd_en is never asserted outside IDLE and never while sys_rst = 1.
- cfg changes mid-frame have no effect until the next LOAD.

## Timing
- Reset values: tx = 1, tx_busy = 0, tx_done = 0, rfifo_rd_en = 0, FSM = IDLE, counters = 0.
- Cycle N: rfifo_rd_en = 1. Cycle N+1: LOAD. tx falls at edge N+2.
- Frame length = (1 + D_WIDTH + P + S) × BAUD_DIV clocks, where P ∈ {0,1} and S ∈ {1,2}.
- tx_done is high in the final clock of the frame. IDLE is reached the cycle after.
- Back-to-back frames: 2-clock gap between frames (IDLE, LOAD), with tx = 1 throughout the gap.
- Reset during a frame: tx = 1 at the next edge, the frame is abandoned and not re-read, and no tx_done is produced.
- cfg_tx_en falling mid-frame: the frame completes normally, then no further read.
- rfifo_empty rising in the same cycle as the IDLE check: no read is issued.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state, accumulator and cfg_par_en/cfg_par_odd inputs are live.
- UART_TX_PARITY_EN undefined: the parity logic is removed, P = 0 always, and the parity inputs remain as ports but are ignored.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum, shared later with the RX successor;
  - the stop-bit and parity mode constants;
  - a function computing BAUD_DIV and checking it is ≥ 4.
- One sub-module, uart_baud_gen. Inputs: clear. Outputs: the one-cycle tick and the count. It is reusable by RX with a mid-bit tick.

## Test plan
Bench settings: CLK_FREQ = 40, BAUD_RATE = 10 (BAUD_DIV = 4), D_WIDTH = 8.
- Send 0xA5, no parity, 1 stop bit. Expected tx: 0,1,0,1,0,0,1,0,1,1, each held 4 clocks. tx_done at clock 40 after LOAD; exactly one rfifo_rd_en.
- Send 0xA5 with parity. Even: parity bit 0. Odd: parity bit 1. Frame length 44 clocks.
- Stop2 = 1 with 3 bytes queued: each frame is 44 clocks (no parity), with 2-clock high gaps between frames and 3 rd_en pulses total.
- Drop cfg_tx_en in the middle of frame 1 with 2 bytes queued: frame 1 completes, then no rd_en and tx stays 1.
- Assert sys_rst during the DATA state: tx = 1 the next cycle, no tx_done, and after release the next queued byte is sent from its start bit.
- Compile without UART_TX_PARITY_EN and set cfg_par_en = 1: the frame is identical to the no-parity case (40 clocks).
